win_acc_16: RTL

Product accumulator that sits directly downstream of the 8-bit Winograd multiplier. It consumes the multiplier's 16-bit products one per cycle over a valid/ready handshake and sums a fixed-length group of them (one Winograd element-wise dot product) into a wide accumulator. It then presents one clipped or truncated 16-bit result to the output-transform stage.

---
 rtl/win_pkg.sv | 21 ++
 rtl/win_acc_clip.sv | 68 ++++++
 rtl/win_acc_16.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/win_pkg.sv
// ---------------------------------------------------------------------------
// win_pkg
// Shared definitions for the Winograd product accumulator slice.
//   win_state_e : group-control states (IDLE, ACC, DONE)
//   WIN_PROD_W  : width of one multiplier product
//   WIN_N_TERMS : default number of products summed per group
//   WIN_ACC_W   : default accumulator width
// ---------------------------------------------------------------------------
package win_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } win_state_e;

  localparam int WIN_PROD_W  = 16;
  localparam int WIN_N_TERMS = 16;
  localparam int WIN_ACC_W   = 24;

endpackage

// File: rtl/win_acc_clip.sv
// ---------------------------------------------------------------------------
// win_acc_clip
// Combinational range test and output narrowing for a finished group sum.
// The sum is judged against the OUT_W range (signed or unsigned, chosen by
// sgn) and then either clipped to the nearest bound or truncated to its low
// OUT_W bits.
//
// Build option:
//   WIN_ACC_SAT_EN defined   : out-of-range sums clip to the range bound
//   WIN_ACC_SAT_EN undefined : res is the low OUT_W bits of sum (wrap)
// ovf reports the range violation identically in both builds.
//
// Ports:
//   sum  in  ACC_W  full-width group sum
//   sgn  in  1      1 = sum is two's complement, 0 = unsigned
//   res  out OUT_W  narrowed result
//   ovf  out 1      sum lies outside the OUT_W range
// ---------------------------------------------------------------------------
module win_acc_clip #(
  parameter int ACC_W = 24,
  parameter int OUT_W = 16
) (
  input  logic [ACC_W-1:0] sum,
  input  logic             sgn,
  output logic [OUT_W-1:0] res,
  output logic             ovf
);

  // Range bounds expressed at accumulator width. S_MIN is the two's
  // complement of S_MAX+1, which is simply the bitwise inverse of S_MAX.
  localparam logic [ACC_W-1:0] U_MAX = {ACC_W{1'b1}} >> (ACC_W - OUT_W);
  localparam logic [ACC_W-1:0] S_MAX = U_MAX >> 1;
  localparam logic [ACC_W-1:0] S_MIN = ~S_MAX;

  logic over;
  logic under;

  // Range test: signed sums can leave the range in either direction,
  // unsigned sums (always non-negative here) only upwards.
  always_comb begin
    over  = 1'b0;
    under = 1'b0;
    if (sgn) begin
      over  = $signed(sum) > $signed(S_MAX);
      under = $signed(sum) < $signed(S_MIN);
    end else begin
      over  = sum > U_MAX;
    end
    ovf = over | under;
  end

  // Output narrowing: clip to the violated bound, or keep the low bits.
`ifdef WIN_ACC_SAT_EN
  always_comb begin
    res = sum[OUT_W-1:0];
    if (over) begin
      res = sgn ? S_MAX[OUT_W-1:0] : U_MAX[OUT_W-1:0];
    end else if (under) begin
      res = S_MIN[OUT_W-1:0];
    end
  end
`else
  always_comb begin
    res = sum[OUT_W-1:0];
  end
`endif

endmodule

// File: rtl/win_acc_16.sv
// ---------------------------------------------------------------------------
// win_acc_16
// Sums a fixed-length group of N_TERMS 16-bit Winograd multiplier products
// into an ACC_W-bit accumulator and presents one OUT_W-bit result.
//
// Build option: WIN_ACC_SAT_EN (see win_acc_clip) selects clipping instead
// of truncation for out-of-range sums.
//
// Ports:
//   clk          in  1      rising-edge clock
//   rst          in  1      asynchronous active-high reset
//   start        in  1      opens a new group (IDLE, or DONE with out_ready)
//   prod_signed  in  1      sampled with start: products are two's complement
//   in_valid     in  1      prod is valid
//   in_ready     out 1      product accepted this cycle (state ACC only)
//   prod         in  16     product from the multiplier
//   out_valid    out 1      acc_out holds a finished result (state DONE)
//   out_ready    in  1      downstream takes acc_out
//   acc_out      out OUT_W  group result, held until the handshake
//   ovf          out 1      group sum fell outside the OUT_W range
//   busy         out 1      state is ACC or DONE
// ---------------------------------------------------------------------------
module win_acc_16
  import win_pkg::*;
#(
  parameter int N_TERMS = WIN_N_TERMS,
  parameter int ACC_W   = WIN_ACC_W,
  parameter int OUT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  prod_signed,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIN_PROD_W-1:0] prod,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      acc_out,
  output logic                  ovf,
  output logic                  busy
);

  localparam int CNT_W = $clog2(N_TERMS + 1);

  win_state_e       state;
  win_state_e       state_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt;
  logic             sgn_q;
  logic             accept;
  logic             last_beat;
  logic             clear_grp;
  logic [OUT_W-1:0] clip_res;
  logic             clip_ovf;

  // Product extension follows the signedness latched at group start, and
  // the sum feeding the clip is the accumulator including the current beat,
  // so the result can be registered on the very beat that ends the group.
  assign prod_ext  = sgn_q ? {{(ACC_W-WIN_PROD_W){prod[WIN_PROD_W-1]}}, prod}
                           : {{(ACC_W-WIN_PROD_W){1'b0}}, prod};
  assign acc_sum   = acc + prod_ext;
  assign accept    = (state == ACC) && in_valid;
  assign last_beat = accept && (cnt == CNT_W'(N_TERMS - 1));
  assign clear_grp = start && ((state == IDLE) || ((state == DONE) && out_ready));

  win_acc_clip #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_clip (
    .sum (acc_sum),
    .sgn (sgn_q),
    .res (clip_res),
    .ovf (clip_ovf)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs. The handshake outputs depend on the
  // state alone so neither ready nor valid loops back through the peers.
  // A start in DONE together with out_ready goes straight back to ACC.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACC;
        end
      end
      ACC: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (last_beat) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          state_nxt = start ? ACC : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: a group opens by clearing the accumulator and counter and
  // latching signedness; each accepted beat adds one extended product; the
  // final beat captures the narrowed result and its range flag, which then
  // stay put until the next group finishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      sgn_q   <= 1'b0;
      acc_out <= '0;
      ovf     <= 1'b0;
    end else begin
      if (clear_grp) begin
        acc   <= '0;
        cnt   <= '0;
        sgn_q <= prod_signed;
      end else if (accept) begin
        acc <= acc_sum;
        cnt <= cnt + CNT_W'(1);
      end
      if (last_beat) begin
        acc_out <= clip_res;
        ovf     <= clip_ovf;
      end
    end
  end

endmodule
